rrot_arb_4: RTL and testbench
=============================

Name: rrot_arb_4

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit right-rotate datapath (3-stage mux2x1 barrel structure, amount 0..7) among four requesters.
- Accepts one request at a time over a valid/ready handshake and registers the operands.
- Drives the rotator, registers the result with the requester ID, and holds it until the consumer accepts.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 (ID width 2).
- DW, 8, data width; fixed at 8 to match the rotator.
- CW, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  4  bit i: requester i has an operation pending.
- req_data  input  32  requester i operand in bits [8i+7:8i].
- req_amt  input  12  requester i rotate amount in bits [3i+2:3i].
- req_ready  output  4  one-hot; bit i high in the cycle requester i's operands are captured.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  8  rotated result.
- resp_id  output  2  index of the requester that owns resp_data.
- busy  output  1  high whenever state is not IDLE.
- op_count  output  16  number of completed response handshakes; wraps modulo 2^16.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rr_ptr=0, op_reg/amt_reg/id_reg=0, resp_valid=0, resp_data=0, resp_id=0, op_count=0, req_ready=0. Reset mid-operation discards the operation with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req_valid is nonzero, the winner is the first set bit searching rr_ptr, rr_ptr+1, ... modulo 4.
  - req_ready[winner]=1 combinationally in this cycle only.
  - On the edge: op_reg<=req_data slice, amt_reg<=req_amt slice, id_reg<=winner, rr_ptr<=(winner+1) mod 4, state<=EXEC.
  - If req_valid is 0, stay in IDLE; req_ready=0.
- EXEC:
  - Rotator computes from op_reg/amt_reg: result[k] = op_reg[(k+amt_reg) mod 8].
  - On the edge: resp_data<=result, resp_id<=id_reg, resp_valid<=1, state<=RESP.
  - req_ready=0.
- RESP:
  - resp_valid=1; resp_data and resp_id are held stable.
  - On resp_valid&&resp_ready: resp_valid<=0, op_count<=op_count+1, state<=IDLE.
  - Otherwise hold indefinitely (backpressure).
  - req_ready=0.
- Timing:
  - Capture edge at cycle N gives resp_valid high from cycle N+1 (after the EXEC edge).
  - Earliest resp_ready handshake is in cycle N+2; the next acceptance is in cycle N+3.
  - Peak throughput is one operation per 3 cycles.
- req_ready is never asserted outside IDLE; requesters hold valid and operands until they see ready.
- A requester dropping req_valid before grant is legal; it is simply not selected.
- Amount 0 gives pass-through. Amount 7 is equivalent to rotate-left by 1.
- rr_ptr changes only at acceptance, so priority is stable while waiting.
- op_count wraps from 0xFFFF to 0x0000 with no flag.

Test Plan:
- Reset, then single request: req_valid=4'b0100, data[23:16]=0x81, amt[8:6]=1. Required: req_ready=4'b0100 in one cycle; resp_valid two edges later; resp_data=0xC0, resp_id=2; op_count=1 after handshake.
- Boundary amounts via requester 0:
  - 0xA5 amt 0 -> 0xA5.
  - 0x01 amt 7 -> 0x02.
  - 0x80 amt 4 -> 0x08.
  - Sweep all 8 amounts on 0x96 against a reference rotate model.
- Fairness: all four req_valid held high with resp_ready=1. Required grant order 0,1,2,3,0 across successive acceptances, 3 cycles apart.
- Priority pointer: after requester 3 is served, assert req_valid=4'b1001. Required: requester 0 is granted first, then requester 3.
- Backpressure: resp_ready low for 5 cycles after resp_valid. Required: resp_data/resp_id stable, req_ready=0, busy=1, op_count unchanged; on resp_ready high, one increment and return to IDLE.
- Asynchronous reset: assert rst_n low mid-EXEC and mid-RESP, off-edge. Required: outputs clear immediately; no spurious response after release; rr_ptr=0; op_count=0.

Source files
------------

// File: rtl/rrot_arb_4_if.sv
// Request/response bundle between four requesters, one consumer and the rotate arbiter.
// The master side drives requests and accepts results; the slave side is the arbiter.
interface rrot_arb_4_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [11:0] req_amt;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_data;
    logic [1:0]  resp_id;

    modport master (
        output req_valid, req_data, req_amt, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_data, req_amt, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/rrot_arb_4.sv
// Round-robin arbiter that shares one 8-bit right-rotate barrel among four requesters.
// One operation in flight: capture (IDLE) -> rotate (EXEC) -> hold result until accepted (RESP).
module rrot_arb_4 #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rrot_arb_4_if.slave   bus,
    output logic          busy,
    output logic [CW-1:0] op_count
);
    localparam int NREQ = 4;
    localparam int DW   = 8;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      rr_ptr_reg;
    logic [DW-1:0]   op_reg;
    logic [2:0]      amt_reg;
    logic [1:0]      id_reg;
    logic [DW-1:0]   resp_data_reg;
    logic [1:0]      resp_id_reg;
    logic            resp_valid_reg;
    logic [CW-1:0]   op_count_reg;

    logic [NREQ-1:0][DW-1:0] data_slice;
    logic [NREQ-1:0][2:0]    amt_slice;
    logic [NREQ-1:0]         vld_rot;
    logic [NREQ-1:0]         grant;
    logic [1:0]              offset;
    logic [1:0]              winner;
    logic                    accept;
    logic [3:0][DW-1:0]      stage;

    assign data_slice = bus.req_data;
    assign amt_slice  = bus.req_amt;

    // Request vector rotated so that bit 0 is the requester currently holding top priority.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_vld_rot
            assign vld_rot[gi] = bus.req_valid[rr_ptr_reg + 2'(gi)];
        end
    endgenerate

    always_comb begin
        offset = 2'd0;
        casez (vld_rot)
            4'b???1: offset = 2'd0;
            4'b??10: offset = 2'd1;
            4'b?100: offset = 2'd2;
            4'b1000: offset = 2'd3;
            default: offset = 2'd0;
        endcase
    end

    assign winner = rr_ptr_reg + offset;

    // Three mux2x1 stages: stage gi rotates right by 2**gi when amt bit gi is set.
    assign stage[0] = op_reg;
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_barrel
            localparam int SH = 1 << gi;
            assign stage[gi+1] = amt_reg[gi]
                ? {stage[gi][SH-1:0], stage[gi][DW-1:SH]}
                : stage[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        grant      = '0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                // Gated by rst_n so no grant is offered while reset is held.
                if (rst_n && (|bus.req_valid)) begin
                    grant      = 4'b0001 << winner;
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (resp_valid_reg && bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg     <= '0;
            op_reg         <= '0;
            amt_reg        <= '0;
            id_reg         <= '0;
            resp_data_reg  <= '0;
            resp_id_reg    <= '0;
            resp_valid_reg <= 1'b0;
            op_count_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg     <= data_slice[winner];
                        amt_reg    <= amt_slice[winner];
                        id_reg     <= winner;
                        rr_ptr_reg <= winner + 2'd1;
                    end
                end
                EXEC: begin
                    resp_data_reg  <= stage[3];
                    resp_id_reg    <= id_reg;
                    resp_valid_reg <= 1'b1;
                end
                RESP: begin
                    if (resp_valid_reg && bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        op_count_reg   <= op_count_reg + 1'b1;
                    end
                end
                default: resp_valid_reg <= 1'b0;
            endcase
        end
    end

    assign bus.req_ready  = grant;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_data  = resp_data_reg;
    assign bus.resp_id    = resp_id_reg;
    assign busy           = (state_reg != IDLE);
    assign op_count       = op_count_reg;
endmodule

// File: tb/tb_rrot_arb_4.sv
// Directed bench for rrot_arb_4: vector table for single operations, then hand-written
// sequences for fairness, priority pointer, backpressure and asynchronous reset.
module tb_rrot_arb_4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    rrot_arb_4_if bus();

    rrot_arb_4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [11:0] amt;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_data;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[12];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [7:0] rot_ref(input logic [7:0] d, input logic [2:0] a);
        logic [15:0] t;
        t = {d, d} >> a;
        return t[7:0];
    endfunction

    function automatic vec_t mk(input int r, input logic [7:0] d, input logic [2:0] a,
                                input logic [7:0] want);
        vec_t v;
        v.valid     = 4'b0001 << r;
        v.data      = 32'(d) << (8 * r);
        v.amt       = 12'(a) << (3 * r);
        v.exp_ready = 4'b0001 << r;
        v.exp_data  = want;
        v.exp_id    = 2'(r);
        return v;
    endfunction

    // One full transaction with an immediately ready consumer.
    task automatic run_op(input vec_t v, input int want_cnt);
        @(negedge clk);
        bus.req_valid = v.valid;
        bus.req_data  = v.data;
        bus.req_amt   = v.amt;
        #1 check("req_ready", 32'(bus.req_ready), 32'(v.exp_ready));
        @(negedge clk);
        bus.req_valid = 4'b0000;
        check("exec_state", {30'd0, busy, bus.resp_valid}, 32'b10);
        check("exec_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("resp_valid", 32'(bus.resp_valid), 32'd1);
        check("resp_data", 32'(bus.resp_data), 32'(v.exp_data));
        check("resp_id", 32'(bus.resp_id), 32'(v.exp_id));
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("op_count", 32'(op_count), 32'(want_cnt));
        check("idle_after", {30'd0, busy, bus.resp_valid}, 32'b00);
        $display("op: valid=%b id=%0d data=0x%02h count=%0d", v.valid, bus.resp_id,
                 bus.resp_data, op_count);
    endtask

    // Holds req_valid and watches n grants; requester i offers 0x11*(i+1) with amount 0.
    task automatic watch_grants(input logic [3:0] valid, input int n, input logic [9:0] order);
        int g;
        int last;
        g = 0;
        last = 0;
        @(negedge clk);
        bus.req_valid  = valid;
        bus.req_data   = 32'h44332211;
        bus.req_amt    = 12'd0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 40 && g < n; c++) begin
            #1;
            if (|bus.req_ready) begin
                check("grant_order", 32'(bus.req_ready), 32'(4'b0001 << order[2*g +: 2]));
                if (g > 0) check("grant_spacing", 32'(c - last), 32'd3);
                $display("grant %0d: req_ready=%b at %0t", g, bus.req_ready, $time);
                last = c;
                g++;
            end
            if (bus.resp_valid) begin
                check("grant_data", 32'(bus.resp_data), 32'h11 * (32'(bus.resp_id) + 1));
                exp_cnt++;
            end
            @(negedge clk);
        end
        check("grant_count", 32'(g), 32'(n));
        bus.req_valid = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.resp_valid) begin
                check("drain_data", 32'(bus.resp_data), 32'h11 * (32'(bus.resp_id) + 1));
                exp_cnt++;
            end
            if (!busy && !bus.resp_valid) break;
            @(negedge clk);
        end
        bus.resp_ready = 1'b0;
        check("grant_idle", 32'(busy), 32'd0);
        check("grant_opcnt", 32'(op_count), 32'(exp_cnt));
    endtask

    initial begin
        bit saw_resp;
        vec_t v;

        bus.req_valid  = 4'b0000;
        bus.req_data   = '0;
        bus.req_amt    = '0;
        bus.resp_ready = 1'b0;

        vecs[0] = mk(2, 8'h81, 3'd1, 8'hC0);
        vecs[1] = mk(0, 8'hA5, 3'd0, 8'hA5);
        vecs[2] = mk(0, 8'h01, 3'd7, 8'h02);
        vecs[3] = mk(0, 8'h80, 3'd4, 8'h08);
        for (int a = 0; a < 8; a++) begin
            vecs[4 + a] = mk(a % 4, 8'h96, 3'(a), rot_ref(8'h96, 3'(a)));
        end

        #12;
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_resp_data", {22'd0, bus.resp_id, bus.resp_data}, 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], i + 1);
        end
        exp_cnt = 12;

        // Fairness: last table op served requester 3, so pointer is back at 0.
        watch_grants(4'b1111, 5, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0});

        // Priority pointer: serve requester 3, then 0 must beat 3.
        exp_cnt++;
        run_op(mk(3, 8'h44, 3'd0, 8'h44), exp_cnt);
        watch_grants(4'b1001, 2, {6'd0, 2'd3, 2'd0});

        // Backpressure: requester 1, 0x3C ror 2 = 0x0F, consumer stalls 5 cycles.
        @(negedge clk);
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h00003C00;
        bus.req_amt   = 12'b000_000_010_000;
        @(negedge clk);
        bus.req_valid = 4'b1111;
        @(negedge clk);
        check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_data", 32'(bus.resp_data), 32'h0F);
            check("bp_id", 32'(bus.resp_id), 32'd1);
            check("bp_ready", 32'(bus.req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_opcnt", 32'(op_count), 32'(exp_cnt));
            @(negedge clk);
        end
        bus.req_valid  = 4'b0000;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        exp_cnt++;
        check("bp_release_cnt", 32'(op_count), 32'(exp_cnt));
        check("bp_release_idle", {30'd0, busy, bus.resp_valid}, 32'b00);
        $display("backpressure: released, count=%0d", op_count);

        // Asynchronous reset in the middle of EXEC, with a request still pending.
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h00AB0000;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_opcnt", 32'(op_count), 32'd0);
        check("rst_exec_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        #3 rst_n = 1'b1;
        saw_resp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid || busy) saw_resp = 1'b1;
        end
        check("rst_exec_no_resp", 32'(saw_resp), 32'd0);

        // Asynchronous reset while a result is held in RESP.
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h00CD0000;
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("pre_rst_resp", 32'(bus.resp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_resp_clear", {21'd0, busy, bus.resp_valid, bus.resp_id, bus.resp_data}, 32'd0);
        check("rst_resp_opcnt", 32'(op_count), 32'd0);
        @(negedge clk);
        #3 rst_n = 1'b1;

        // Pointer must be back at 0: all requesting selects requester 0.
        v.valid     = 4'b1111;
        v.data      = 32'h7766555A;
        v.amt       = 12'b101_110_111_011;
        v.exp_ready = 4'b0001;
        v.exp_data  = 8'h4B;
        v.exp_id    = 2'd0;
        run_op(v, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end
endmodule
